permute_engine: RTL and testbench
=================================

PERMUTE_ENGINE -- requirements
Module: permute_engine

Interface
REQ-001 The module SHALL have parameter DIM, default 5, which sets the matrix side; the line width is W = DIM*DIM.
REQ-002 The module SHALL have parameter NUM_LINES, default 64, which sets the number of lines per job.
REQ-003 The module SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled in IDLE only.
- mode  in  2  permutation select; latched at job start.
- inv  in  1  inverse-mapping select; latched at job start.
- in_valid  in  1  input line valid.
- in_ready  out  1  engine can accept a line.
- line_in  in  W  input line; bit index = DIM*y + x.
- out_valid  out  1  output line valid.
- out_ready  in  1  downstream accepts the output line.
- line_out  out  W  permuted line.
- cnt_value  out  $clog2(NUM_LINES+1)  count of lines delivered in the current job.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last line is delivered.

Function
REQ-004 FSM states SHALL be IDLE, ACCEPT, PERMUTE, EMIT and FINISH.
REQ-005 State transitions SHALL be:
- IDLE->ACCEPT on start=1; mode and inv latched, count cleared.
- ACCEPT->PERMUTE on in_valid&&in_ready.
- PERMUTE->EMIT unconditionally.
- EMIT->ACCEPT on out_valid&&out_ready when count+1<NUM_LINES; else EMIT->FINISH.
- FINISH->IDLE unconditionally.
REQ-006 in_ready SHALL be high only in ACCEPT; line_in SHALL be captured into the line register on handshake.
REQ-007 In PERMUTE, the line register SHALL be overwritten with the selected mapping of itself.
- Each output bit (X,Y) takes input bit (x,y).
- All arithmetic is mod DIM.
REQ-008 Forward mappings (inv=0):
- mode 0 identity.
- mode 1 transpose: (x,y)->(y,x).
- mode 2 pi: (x,y)->(y, 2x+3y).
- mode 3 row rotate: (x,y)->(x+1, y).
REQ-009 Inverse mappings (inv=1):
- mode 0 and mode 1 same as forward.
- mode 2: (X,Y)->(X+3Y, X).
- mode 3: (x,y)->(x-1, y).
REQ-010 out_valid SHALL be high only in EMIT; line_out SHALL equal the line register and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 cnt_value SHALL increment on each output handshake and SHALL hold NUM_LINES through FINISH and IDLE until the next start.
REQ-012 Latency from input handshake to out_valid SHALL be 2 cycles; minimum throughput SHALL be one line per 3 cycles.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 done SHALL be high exactly in FINISH.

Reset
REQ-015 On rst=1 the module SHALL immediately enter IDLE, including mid-job.
REQ-016 During reset the module SHALL clear the line register, count, latched mode and latched inv.
REQ-017 Reset output values SHALL be: in_ready=0, out_valid=0, busy=0, done=0, line_out=0, cnt_value=0.

Configuration
REQ-018 With macro PERMUTE_ENGINE_INVERSE_EN defined, inv SHALL select the inverse mappings of REQ-009.
REQ-019 With PERMUTE_ENGINE_INVERSE_EN undefined, inv SHALL be ignored, forward mappings SHALL always apply, and the port list SHALL be unchanged.

Structure
REQ-020 A shared package permute_pkg SHALL hold the FSM state encoding and the mode encoding constants (MODE_ID, MODE_TRANSPOSE, MODE_PI, MODE_ROT).
REQ-021 The mapping SHALL be a combinational sub-module permute_map (DIM parameter; inputs line, mode, inv; output line), instantiated once.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (DIM=5):
- mode=1, line_in=25'h0000002 -> line_out=25'h0000020.
- mode=2, inv=0, line_in=25'h0000002 -> line_out=25'h0000400; with the macro defined, mode=2, inv=1, line_in=25'h0000400 -> line_out=25'h0000002.
- mode=3, inv=0, line_in=25'h0000010 -> line_out=25'h0000001; mode=0 on any value returns it unchanged.
- NUM_LINES=64 with out_ready held low 5 cycles on line 10 -> line_out stable throughout; 64 lines delivered; cnt_value=64; a single done pulse.
- rst asserted after line 30 -> in IDLE the same cycle with cnt_value=0; next start runs a full 64-line job.
- start pulsed while busy -> no effect on count or latched mode.

Source files
------------

// File: rtl/permute_pkg.sv
// rtl/permute_pkg.sv - shared FSM state and mode encodings for the permute engine
// Contents: state constants (ST_*), mode constants (MODE_*), and the
// dest_index helper that gives the destination bit of an input bit (x,y).
package permute_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACCEPT  = 3'd1;
    localparam logic [2:0] ST_PERMUTE = 3'd2;
    localparam logic [2:0] ST_EMIT    = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    localparam logic [1:0] MODE_ID        = 2'd0;
    localparam logic [1:0] MODE_TRANSPOSE = 2'd1;
    localparam logic [1:0] MODE_PI        = 2'd2;
    localparam logic [1:0] MODE_ROT       = 2'd3;

    // Destination bit index (DIM*Y + X) for input bit (x,y).
    // Inverse pi and inverse rotate undo their forward counterparts;
    // identity and transpose are their own inverses.
    function automatic int dest_index(input int dim, input logic [1:0] mode,
                                      input logic inv, input int x, input int y);
        int dx;
        int dy;
        dx = x;
        dy = y;
        case (mode)
            MODE_TRANSPOSE: begin
                dx = y;
                dy = x;
            end
            MODE_PI: begin
                if (inv) begin
                    dx = (x + 3 * y) % dim;
                    dy = x;
                end else begin
                    dx = y;
                    dy = (2 * x + 3 * y) % dim;
                end
            end
            MODE_ROT: begin
                if (inv) dx = (x + dim - 1) % dim;
                else     dx = (x + 1) % dim;
            end
            default: ;
        endcase
        return dim * dy + dx;
    endfunction

endpackage

// File: rtl/permute_map.sv
// rtl/permute_map.sv - combinational DIMxDIM bit-plane permutation
// Ports: line_in (DIM*DIM source line), mode (MODE_*), inv (inverse select),
//        line_out (permuted line). Bit index is DIM*y + x.
module permute_map
    import permute_pkg::*;
#(
    parameter int DIM = 5
) (
    input  logic [DIM*DIM-1:0] line_in,
    input  logic [1:0]         mode,
    input  logic               inv,
    output logic [DIM*DIM-1:0] line_out
);

    localparam int IW = $clog2(DIM * DIM);

    // Every mapping is a bijection, so each output bit is written exactly once.
    always_comb begin
        line_out = '0;
        for (int y = 0; y < DIM; y++) begin
            for (int x = 0; x < DIM; x++) begin
                line_out[IW'(dest_index(DIM, mode, inv, x, y))] = line_in[IW'(DIM * y + x)];
            end
        end
    end

endmodule

// File: rtl/permute_engine.sv
// rtl/permute_engine.sv - line-at-a-time permutation engine with job framing
// Ports: clk, rst (async active-high); start/mode/inv job request;
//        in_valid/in_ready/line_in input stream; out_valid/out_ready/line_out
//        output stream; cnt_value lines delivered; busy; done (FINISH pulse).
// Build option: PERMUTE_ENGINE_INVERSE_EN enables inverse mappings via inv;
//        without it inv is ignored and forward mappings always apply.
module permute_engine
    import permute_pkg::*;
#(
    parameter int DIM       = 5,
    parameter int NUM_LINES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic                             inv,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DIM*DIM-1:0]               line_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DIM*DIM-1:0]               line_out,
    output logic [$clog2(NUM_LINES+1)-1:0]   cnt_value,
    output logic                             busy,
    output logic                             done
);

    localparam int CW = $clog2(NUM_LINES + 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [DIM*DIM-1:0] line_q;
    logic [DIM*DIM-1:0] line_mapped;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         mode_q;
    logic               inv_eff;
    logic               last_line;

`ifdef PERMUTE_ENGINE_INVERSE_EN
    logic inv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           inv_q <= 1'b0;
        else if (state == ST_IDLE && start) inv_q <= inv;
    end

    assign inv_eff = inv_q;
`else
    logic unused_inv;

    assign unused_inv = inv;
    assign inv_eff    = 1'b0;
`endif

    assign last_line = (cnt_q == CW'(NUM_LINES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_ACCEPT;
            ST_ACCEPT:  if (in_valid) state_nxt = ST_PERMUTE;
            ST_PERMUTE: state_nxt = ST_EMIT;
            ST_EMIT:    if (out_ready) state_nxt = last_line ? ST_FINISH : ST_ACCEPT;
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            line_q <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_ID;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        cnt_q  <= '0;
                    end
                end
                ST_ACCEPT:  if (in_valid) line_q <= line_in;
                ST_PERMUTE: line_q <= line_mapped;
                ST_EMIT:    if (out_ready) cnt_q <= cnt_q + CW'(1);
                default: ;
            endcase
        end
    end

    permute_map #(
        .DIM(DIM)
    ) u_map (
        .line_in (line_q),
        .mode    (mode_q),
        .inv     (inv_eff),
        .line_out(line_mapped)
    );

    assign in_ready  = (state == ST_ACCEPT);
    assign out_valid = (state == ST_EMIT);
    assign line_out  = line_q;
    assign cnt_value = cnt_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FINISH);

endmodule

// File: tb/tb_permute_engine.sv
// tb/tb_permute_engine.sv - directed self-checking bench for permute_engine
module tb_permute_engine;

    localparam int NL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        inv = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] line_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] line_out;
    logic [6:0]  cnt_value;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    permute_engine #(.DIM(5), .NUM_LINES(NL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .inv      (inv),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .line_in  (line_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .line_out (line_out),
        .cnt_value(cnt_value),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_line(input logic [24:0] d);
        int n = 0;
        in_valid = 1'b1;
        line_in  = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        line_in  = '0;
    endtask

    task automatic recv_line(input logic [24:0] e, input bit stall, input int idx, output int waits);
        waits = 0;
        out_ready = !stall;
        @(negedge clk);
        while (!out_valid && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check($sformatf("out_valid_wait[%0d]", idx), 32'(out_valid), 32'd1);
        check($sformatf("line_out[%0d]", idx), 32'(line_out), 32'(e));
        if (stall) begin
            repeat (5) begin
                @(negedge clk);
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_line", 32'(line_out), 32'(e));
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] m, input logic iv, input logic [24:0] din,
                           input logic [24:0] dexp, input bit vary, input int stall_at,
                           input int restart_at, input int abort_at);
        logic [24:0] d;
        logic [24:0] e;
        int w;
        @(posedge clk);
        #1;
        mode  = m;
        inv   = iv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'd0;
        inv   = 1'b0;
        check("job_busy", 32'(busy), 32'd1);
        check("job_cnt_clear", 32'(cnt_value), 32'd0);
        for (int i = 0; i < NL; i++) begin
            d = vary ? (din ^ 25'(i)) : din;
            e = vary ? (dexp ^ 25'(i)) : dexp;
            if (i == restart_at) begin
                start = 1'b1;
                mode  = 2'd2;
                inv   = ~iv;
                @(posedge clk);
                #1;
                start = 1'b0;
                mode  = 2'd0;
                inv   = 1'b0;
                check("restart_cnt", 32'(cnt_value), 32'(i));
                check("restart_busy", 32'(busy), 32'd1);
            end
            send_line(d);
            recv_line(e, i == stall_at, i, w);
            check($sformatf("latency[%0d]", i), 32'(w), 32'd1);
            check($sformatf("cnt[%0d]", i), 32'(cnt_value), 32'(i + 1));
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_cnt", 32'(cnt_value), 32'd0);
                check("abort_out_valid", 32'(out_valid), 32'd0);
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_line_out", 32'(line_out), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        check("finish_done", 32'(done), 32'd1);
        check("finish_busy", 32'(busy), 32'd1);
        check("finish_cnt", 32'(cnt_value), 32'(NL));
        @(posedge clk);
        #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cnt", 32'(cnt_value), 32'(NL));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_line_out", 32'(line_out), 32'd0);
        check("rst_cnt", 32'(cnt_value), 32'd0);
        rst = 1'b0;

        // transpose, with a 5-cycle output stall on line 10
        run_job(2'd1, 1'b0, 25'h0000002, 25'h0000020, 1'b0, 10, -1, -1);
        // pi forward
        run_job(2'd2, 1'b0, 25'h0000002, 25'h0000400, 1'b0, -1, -1, -1);
`ifdef PERMUTE_ENGINE_INVERSE_EN
        run_job(2'd2, 1'b1, 25'h0000400, 25'h0000002, 1'b0, -1, -1, -1);
        run_job(2'd3, 1'b1, 25'h0000001, 25'h0000010, 1'b0, -1, -1, -1);
`else
        // inv has no effect in this build
        run_job(2'd2, 1'b1, 25'h0000002, 25'h0000400, 1'b0, -1, -1, -1);
        run_job(2'd3, 1'b1, 25'h0000010, 25'h0000001, 1'b0, -1, -1, -1);
`endif
        // row rotate, with a start pulse mid-job that must be ignored
        run_job(2'd3, 1'b0, 25'h0000010, 25'h0000001, 1'b0, -1, 20, -1);
        // identity on varying data
        run_job(2'd0, 1'b0, 25'h1A5A5A5, 25'h1A5A5A5, 1'b1, -1, -1, -1);
        // reset after line 30, then a full job
        run_job(2'd1, 1'b0, 25'h0000002, 25'h0000020, 1'b0, -1, -1, 30);
        run_job(2'd1, 1'b0, 25'h0000002, 25'h0000020, 1'b0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
